// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared encodings for the multi-cycle MIPS-subset control
//                unit: FSM states, opcode/funct values, ALU control codes,
//                mux select encodings and the per-state control vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // FSM state encoding, also visible on the debug 'state' port
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct field, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function codes driven on alu_ctl
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // alu_op encoding
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_src_b encoding
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pc_source encoding
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control vector held in a register alongside the state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       last;       // final cycle of a legal instruction
    } ctl_t;

    // Moore control vector for a given state; unlisted fields stay 0
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.last       = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.last      = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.last      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.last          = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
                c.last      = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.last      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // True for every opcode the control unit can sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_dec
//  Description : Combinational ALU control decoder, alu_op/funct -> alu_ctl.
//                Shared between the control unit and the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl
);

    // Fixed add/sub for address and branch work, funct decode for R-type;
    // unknown functs and the unused alu_op code fall back to add
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_multiciclo
//  Description : Multi-cycle Moore control unit for the MIPS-subset
//                datapath. Registers state and its control vector together;
//                write/load strobes are gated by the run enable so a stall
//                never produces a spurious write.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_multiciclo
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       alu_ctl,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    ctl_t             r_ctl;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_next;
    logic [2:0]       w_alu_ctl;

    // Next-state decode; opcode is only consulted in DECODE and MEM_ADDR
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = S_MEM_WB;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB,
            S_BRANCH, S_JUMP, S_ADDI_WB:
                         w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    // State, its control vector and the retired counter advance together;
    // en=0 freezes all three
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctl   <= '0;
            r_cnt   <= '0;
        end else if (en) begin
            r_state <= w_next;
            r_ctl   <= ctl_of(w_next);
            if (r_ctl.last) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op  (r_ctl.alu_op),
        .funct   (funct),
        .alu_ctl (w_alu_ctl)
    );

    // Strobes are masked by en; mux selects follow the held state
    always_comb begin
        pc_write      = en & r_ctl.pc_write;
        pc_write_cond = en & r_ctl.pc_write_cond;
        pc_en         = en & (r_ctl.pc_write | (r_ctl.pc_write_cond & zero));
        mem_read      = en & r_ctl.mem_read;
        mem_write     = en & r_ctl.mem_write;
        ir_write      = en & r_ctl.ir_write;
        reg_write     = en & r_ctl.reg_write;
        instr_done    = en & r_ctl.last;
        illegal_op    = en & (r_state == S_DECODE) & ~is_legal_op(opcode);
        i_or_d        = r_ctl.i_or_d;
        mem_to_reg    = r_ctl.mem_to_reg;
        reg_dst       = r_ctl.reg_dst;
        alu_src_a     = r_ctl.alu_src_a;
        alu_src_b     = r_ctl.alu_src_b;
        alu_op        = r_ctl.alu_op;
        pc_source     = r_ctl.pc_source;
        alu_ctl       = (r_state == S_IDLE) ? 3'b000 : w_alu_ctl;
        state         = r_state;
        instr_cnt     = r_cnt;
    end

endmodule
`default_nettype wire
